// File: rtl/player1_motion.sv
// Player 1 motion stage: integrates movement code and jump phase into a clamped screen position once per motion tick.
// Optional build macro PLAYER1_MOTION_WRAP_EN makes horizontal motion wrap around instead of clamping.
module player1_motion #(
    parameter int TICK_DIV = 1_000_000,
    parameter int H_STEP   = 2,
    parameter int V_STEP   = 3,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 608,
    parameter int Y_TOP    = 40,
    parameter int Y_GROUND = 400,
    parameter int X_SPAWN  = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] state,
    input  logic [3:0] player1_state,
    input  logic [1:0] player1_jump,
    output logic [9:0] player1_x,
    output logic [9:0] player1_y,
    output logic       facing_left,
    output logic       airborne,
    output logic       land_pulse
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    localparam logic signed [10:0] H_STEP_S   = 11'(H_STEP);
    localparam logic signed [10:0] V_STEP_S   = 11'(V_STEP);
    localparam logic signed [10:0] X_MIN_S    = 11'(X_MIN);
    localparam logic signed [10:0] X_MAX_S    = 11'(X_MAX);
    localparam logic signed [10:0] Y_TOP_S    = 11'(Y_TOP);
    localparam logic signed [10:0] Y_GROUND_S = 11'(Y_GROUND);
    localparam logic [9:0]         SPAWN_X    = 10'(X_SPAWN);
    localparam logic [9:0]         GROUND_Y   = 10'(Y_GROUND);

    logic [CNT_W-1:0]   count;
    logic [2:0]         prev_state;
    logic               level_on;
    logic               level_entry;
    logic               tick;
    logic signed [10:0] x_cur;
    logic signed [10:0] y_cur;
    logic signed [10:0] x_sum;
    logic signed [10:0] y_sum;
    logic [9:0]         x_next;
    logic [9:0]         y_next;
    logic               face_next;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        level_on    = (state != 3'd0);
        level_entry = (prev_state == 3'd0) && level_on;
        tick        = level_on && (count == CNT_LAST);

        x_cur     = signed'({1'b0, player1_x});
        y_cur     = signed'({1'b0, player1_y});
        x_sum     = x_cur;
        face_next = facing_left;
        case (player1_state)
            4'd7: begin
                x_sum     = x_cur + H_STEP_S;
                face_next = 1'b0;
            end
            4'd2: begin
                x_sum     = x_cur - H_STEP_S;
                face_next = 1'b1;
            end
            default: ;
        endcase

`ifdef PLAYER1_MOTION_WRAP_EN
        if (x_sum > X_MAX_S)
            x_next = 10'(X_MIN_S + (x_sum - X_MAX_S) - 11'sd1);
        else if (x_sum < X_MIN_S)
            x_next = 10'(X_MAX_S + (x_sum - X_MIN_S));
        else
            x_next = 10'(x_sum);
`else
        if (x_sum > X_MAX_S)
            x_next = 10'(X_MAX_S);
        else if (x_sum < X_MIN_S)
            x_next = 10'(X_MIN_S);
        else
            x_next = 10'(x_sum);
`endif

        // Rising wins; otherwise gravity pulls down whenever above ground.
        y_sum  = y_cur;
        y_next = player1_y;
        if (player1_jump == 2'd1) begin
            y_sum  = y_cur - V_STEP_S;
            y_next = (y_sum < Y_TOP_S) ? 10'(Y_TOP_S) : 10'(y_sum);
        end else if (y_cur < Y_GROUND_S) begin
            y_sum  = y_cur + V_STEP_S;
            y_next = (y_sum > Y_GROUND_S) ? 10'(Y_GROUND_S) : 10'(y_sum);
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count       <= '0;
            prev_state  <= 3'd0;
            player1_x   <= SPAWN_X;
            player1_y   <= GROUND_Y;
            facing_left <= 1'b0;
            airborne    <= 1'b0;
            land_pulse  <= 1'b0;
        end else begin
            prev_state <= state;
            land_pulse <= 1'b0;
            if (!level_on) begin
                count <= '0;
            end else if (level_entry) begin
                count     <= '0;
                player1_x <= SPAWN_X;
                player1_y <= GROUND_Y;
                airborne  <= 1'b0;
            end else if (tick) begin
                count       <= '0;
                player1_x   <= x_next;
                player1_y   <= y_next;
                facing_left <= face_next;
                airborne    <= (y_next != GROUND_Y);
                land_pulse  <= (player1_y != GROUND_Y) && (y_next == GROUND_Y);
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule
